// File: rtl/aim65_pkg.sv
// aim65_pkg: shared types and constants for the AIM65 ROM download path.
package aim65_pkg;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_TAIL
  } ld_state_e;

  // ioctl_index values the HPS uses for each ROM image
  localparam logic [7:0] IDX_MONITOR   = 8'd0;
  localparam logic [7:0] IDX_BASIC     = 8'd1;
  localparam logic [7:0] IDX_ASSEMBLER = 8'd2;

  // CPU-visible base addresses of the ROM images
  localparam logic [15:0] BASE_MONITOR   = 16'hE000;
  localparam logic [15:0] BASE_BASIC     = 16'hB000;
  localparam logic [15:0] BASE_ASSEMBLER = 16'hD000;

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: 2-entry synchronous FIFO. A pop and a push in the same cycle
// are both honoured even when full, because the pop frees the slot first.
module loader_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_q, rd_q;
  logic [1:0]            cnt_q;
  logic                  do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage; the slot being popped is read before it can be overwritten
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: buffers the HPS ioctl byte stream of one ROM image and writes it
// into the ROM backing BRAM, holding the CPU in reset until the image is in.
module rom_loader
  import aim65_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 8,
  parameter int         DEPTH      = 8192,
  parameter logic [7:0] INDEX      = IDX_MONITOR,
  parameter int         HOLD_TAIL  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [26:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [7:0]            checksum
);
  localparam int              FW        = ADDR_WIDTH + DATA_WIDTH;
  localparam int              TW        = (HOLD_TAIL > 1) ? $clog2(HOLD_TAIL) : 1;
  localparam logic [26:0]     DEPTH_A   = 27'(DEPTH);
  localparam logic [TW-1:0]   TAIL_LOAD = TW'(HOLD_TAIL - 1);
  localparam logic [ADDR_WIDTH:0] BC_MAX = '1;

  ld_state_e             state_q;
  logic [TW-1:0]         tail_q;
  logic                  ioctl_wait_q, mem_we_q, cpu_hold_q;
  logic                  load_done_q, load_err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic [ADDR_WIDTH:0]   byte_count_q;
  logic [7:0]            checksum_q;
  // After a reset, a download still in flight must be ignored until the
  // HPS lowers ioctl_download; this flag blocks re-entry until then.
  logic                  dl_block_q;

  logic          start, in_load, addr_ok, drop;
  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_dout;

  assign start      = ioctl_download && (ioctl_index == INDEX) && !dl_block_q;
  assign in_load    = (state_q == ST_LOAD);
  assign addr_ok    = (ioctl_addr < DEPTH_A);
  assign fifo_pop   = !fifo_empty && mem_ready;
  assign fifo_push  = in_load && ioctl_wr && addr_ok && (!fifo_full || fifo_pop);
  assign drop       = in_load && ioctl_wr && !fifo_push;
  assign fifo_flush = start && ((state_q == ST_IDLE) || (state_q == ST_TAIL));

  loader_fifo #(.WIDTH(FW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({ioctl_addr[ADDR_WIDTH-1:0], ioctl_dout}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer plus registered write port, status and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tail_q       <= '0;
      ioctl_wait_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
      dl_block_q   <= 1'b1;
    end else begin
      ioctl_wait_q <= !fifo_empty;
      mem_we_q     <= fifo_pop;
      if (!ioctl_download) dl_block_q <= 1'b0;
      if (fifo_pop) begin
        mem_addr_q <= fifo_dout[FW-1:DATA_WIDTH];
        mem_data_q <= fifo_dout[DATA_WIDTH-1:0];
      end
      // Statistics follow the write strobe by one cycle
      if (mem_we_q) begin
        if (byte_count_q != BC_MAX) byte_count_q <= byte_count_q + 1'b1;
        checksum_q <= checksum_q + 8'(mem_data_q);
      end

      unique case (state_q)
        ST_IDLE, ST_TAIL: begin
          if (start) begin
            state_q      <= ST_LOAD;
            cpu_hold_q   <= 1'b1;
            byte_count_q <= '0;
            checksum_q   <= '0;
            load_err_q   <= 1'b0;
            load_done_q  <= 1'b0;
          end else if (state_q == ST_TAIL) begin
            if (tail_q == '0) begin
              state_q     <= ST_IDLE;
              cpu_hold_q  <= 1'b0;
              load_done_q <= !load_err_q;
            end else begin
              tail_q <= tail_q - 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (drop) load_err_q <= 1'b1;
          if (!ioctl_download) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ST_TAIL;
            tail_q  <= TAIL_LOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized downloads against a transaction-level
// model (list of expected writes, error flag, count and byte sum).
module tb_rom_loader;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 8192;
  localparam int HOLD  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [26:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          mem_ready = 1'b1;
  logic          ioctl_wait, mem_we, cpu_hold, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW:0]   byte_count;
  logic [7:0]    checksum;

  always #5 clk = ~clk;

  rom_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INDEX(8'd0), .HOLD_TAIL(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .byte_count(byte_count), .checksum(checksum)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  bit          rnd_rdy = 1'b0;
  bit          model_on = 1'b0;
  bit          exp_err = 1'b0;
  logic [23:0] got[$];
  logic [23:0] exp_q[$];
  // model's view of the last completed download
  logic [AW:0] m_bc = '0;
  logic [7:0]  m_cs = '0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;

  // write-port monitor
  always @(negedge clk) if (mem_we === 1'b1) got.push_back({mem_addr, mem_data});

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ioctl_wait !== 1'b0 && n < 300) begin tick(); n++; end
    if (n >= 300) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  // HPS-like strobe: waits for back-pressure to clear before each byte
  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    wait_idle();
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    tick();
    if (rnd_rdy) repeat ($urandom_range(0, 2)) tick();
    if (model_on) begin
      if (a < DEPTH) exp_q.push_back({a[15:0], d});
      else exp_err = 1'b1;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    got.delete(); exp_q.delete();
    exp_err = 1'b0;
    model_on = (idx == 8'd0);
    tick();
  endtask

  // Ends a download and checks the outcome against the model
  task automatic end_dl(input bit exact);
    int   n = 0;
    int   sum = 0;
    logic pd = 1'b0;
    wait_idle();
    ioctl_download = 1'b0;
    while (n < 400) begin
      tick();
      if (cpu_hold !== 1'b1) break;
      pd = load_done;
      n++;
    end
    chk("hold_release", cpu_hold, 0);
    chk("done_low_during_hold", pd, 0);
    if (exact) chk("hold_cycles", n, HOLD + 1);
    foreach (exp_q[i]) sum += int'(exp_q[i][7:0]);
    m_bc = (AW+1)'(exp_q.size());
    m_cs = sum[7:0];
    m_err = exp_err;
    m_done = !exp_err;
    chk("wr_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("wr_entry", got[i], exp_q[i]);
    chk("byte_count", byte_count, m_bc);
    chk("checksum", checksum, m_cs);
    chk("load_err", load_err, m_err);
    chk("load_done", load_done, m_done);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wait"}, ioctl_wait, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, load_err, 0);
    chk({tag, "_bc"}, byte_count, 0);
    chk({tag, "_cs"}, checksum, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          len;
    logic [26:0] a;

    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) tick();

    // 16 bytes 0x01..0x10, memory always ready
    start_dl(8'd0);
    chk("hold_rise", cpu_hold, 1);
    for (int k = 0; k < 16; k++) send_byte(27'(k), 8'(k + 1));
    end_dl(1'b1);
    chk("basic_cs_88", checksum, 8'h88);

    // other index is ignored entirely
    start_dl(8'd1);
    chk("ign_hold", cpu_hold, 0);
    for (int k = 0; k < 4; k++) send_byte(27'(k), 8'hA0 + 8'(k));
    ioctl_download = 1'b0;
    repeat (3) tick();
    chk("ign_writes", got.size(), 0);
    chk("ign_hold_end", cpu_hold, 0);
    chk("ign_bc", byte_count, m_bc);
    chk("ign_cs", checksum, m_cs);
    chk("ign_done", load_done, m_done);
    chk("ign_err", load_err, m_err);

    // same stream with the write port stalled mid-stream
    start_dl(8'd0);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        wait_idle();
        mem_ready = 1'b0;
        ioctl_wr = 1'b1; ioctl_addr = 27'(k); ioctl_dout = 8'(k + 1);
        tick();
        ioctl_wr = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_wait", ioctl_wait, 1);
          chk("stall_we", mem_we, 0);
        end
        mem_ready = 1'b1;
        exp_q.push_back({16'(k), 8'(k + 1)});
      end else begin
        send_byte(27'(k), 8'(k + 1));
      end
    end
    end_dl(1'b1);
    chk("stall_cs_88", checksum, 8'h88);

    // out-of-range byte, with the last valid offset alongside
    start_dl(8'd0);
    send_byte(27'd0, 8'h11);
    send_byte(27'(DEPTH - 1), 8'h22);
    send_byte(27'(DEPTH), 8'h33);
    send_byte(27'd5, 8'h44);
    end_dl(1'b1);

    // full FIFO with nothing draining: third byte is dropped
    start_dl(8'd0);
    mem_ready = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 27'd0; ioctl_dout = 8'hAA; tick();
    ioctl_addr = 27'd1; ioctl_dout = 8'hBB; tick();
    ioctl_addr = 27'd2; ioctl_dout = 8'hCC; tick();
    ioctl_wr = 1'b0;
    chk("full_drop_err", load_err, 1);
    mem_ready = 1'b1;
    tick();
    exp_q.push_back({16'd0, 8'hAA});
    exp_q.push_back({16'd1, 8'hBB});
    exp_err = 1'b1;
    end_dl(1'b1);

    // full FIFO popping in the same cycle: push accepted
    start_dl(8'd0);
    mem_ready = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 27'd7; ioctl_dout = 8'h5A; tick();
    ioctl_addr = 27'd8; ioctl_dout = 8'hA5; tick();
    mem_ready = 1'b1;
    ioctl_addr = 27'd9; ioctl_dout = 8'h3C; tick();
    ioctl_wr = 1'b0;
    chk("pushpop_no_err", load_err, 0);
    tick();
    exp_q.push_back({16'd7, 8'h5A});
    exp_q.push_back({16'd8, 8'hA5});
    exp_q.push_back({16'd9, 8'h3C});
    end_dl(1'b1);

    // new download during the hold tail
    start_dl(8'd0);
    send_byte(27'd1, 8'h10);
    send_byte(27'd2, 8'h20);
    wait_idle();
    ioctl_download = 1'b0;
    repeat (6) begin
      tick();
      chk("tail_hold", cpu_hold, 1);
    end
    start_dl(8'd0);
    chk("reenter_hold", cpu_hold, 1);
    chk("reenter_bc_clr", byte_count, 0);
    chk("reenter_done", load_done, 0);
    send_byte(27'd3, 8'h30);
    send_byte(27'd4, 8'h40);
    end_dl(1'b1);

    // reset in the middle of a download
    start_dl(8'd0);
    for (int k = 0; k < 4; k++) send_byte(27'(k), 8'(k + 1));
    reset = 1'b1;
    tick();
    chk_all_zero("abort");
    reset = 1'b0;
    got.delete();
    model_on = 1'b0;
    for (int k = 4; k < 16; k++) send_byte(27'(k), 8'(k + 1));
    chk("abort_writes", got.size(), 0);
    chk("abort_hold", cpu_hold, 0);
    ioctl_download = 1'b0;
    repeat (2) tick();
    chk("abort_bc", byte_count, 0);

    // randomized downloads with a jittery write port
    rnd_rdy = 1'b1;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 24);
      start_dl(8'd0);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 9))
          0:       a = 27'(DEPTH) + 27'($urandom_range(0, 5000));
          1:       a = 27'($urandom);
          default: a = 27'($urandom_range(0, DEPTH - 1));
        endcase
        send_byte(a, 8'($urandom));
      end
      end_dl(1'b0);
    end
    rnd_rdy = 1'b0;
    mem_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Download-side writer for the AIM65 ROM images: it takes the MiSTer HPS ioctl byte stream, buffers it, and writes it into the ROM's backing BRAM through a dedicated write port. It holds the 6502 in reset while a download is in progress and reports completion, the byte count, a checksum and errors. It sits between hps_io and the ROM/BRAM write port, alongside the CPU-side synchronous read path.

## Interface
Parameters:
- ADDR_WIDTH, 16: memory write-address width.
- DATA_WIDTH, 8: data width; must equal the ioctl byte width.
- DEPTH, 8192: number of writable words; valid offsets are 0..DEPTH-1.
- INDEX, 8'd0: ioctl_index value that selects this loader.
- HOLD_TAIL, 16: cycles cpu_hold stays asserted after the download ends.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  image selector.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  27  byte offset within the image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to the HPS.
- mem_ready  in  1  BRAM write port free this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  DATA_WIDTH  write data.
- cpu_hold  out  1  hold the CPU in reset.
- load_done  out  1  the last download completed without error (level).
- load_err  out  1  sticky error for the current or last download.
- byte_count  out  ADDR_WIDTH+1  bytes written to memory.
- checksum  out  8  sum of written bytes, modulo 256.

## Operation
- States: IDLE, LOAD, DRAIN, TAIL.
- IDLE to LOAD: ioctl_download=1 and ioctl_index==INDEX.
  - On entry: byte_count, checksum, load_err and load_done are cleared, and the FIFO is flushed.
- A download with any other index is ignored entirely: outputs and state are unchanged.
- LOAD behaviour per strobe:
  - ioctl_wr=1 with ioctl_addr<DEPTH pushes {addr[ADDR_WIDTH-1:0], dout} into a 2-entry FIFO.
  - ioctl_wr=1 with ioctl_addr>=DEPTH drops the byte and sets load_err.
  - A push into a full FIFO drops the byte and sets load_err.
- FIFO pop: when the FIFO is non-empty and mem_ready=1, mem_we=1 with the head entry, byte_count increments and checksum += data.
- LOAD to DRAIN: on the fall of ioctl_download. A strobe arriving in the same cycle as the fall is still accepted.
- DRAIN to TAIL: when the FIFO is empty. The tail counter loads HOLD_TAIL-1.
- TAIL to IDLE: when the counter reaches 0. At that point cpu_hold drops and load_done = ~load_err.
- A new matching download during TAIL re-enters LOAD immediately; cpu_hold stays high throughout.
- cpu_hold is 1 in LOAD, DRAIN and TAIL, and 0 in IDLE.
- byte_count saturates at 2^(ADDR_WIDTH+1)-1. Checksum wraps modulo 256.

## Timing
- Reset values: ioctl_wait=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, load_done=0, load_err=0, byte_count=0, checksum=0, state=IDLE, FIFO empty.
- Reset in mid-download aborts immediately. All outputs take their reset values on the next edge, and the remaining strobes of that download are ignored until ioctl_download next rises.
- All outputs are registered.
- Latency:
  - A strobe at edge N is in the FIFO at N+1.
  - mem_we is high during cycle N+1 if mem_ready=1 at edge N+1.
  - byte_count and checksum update at edge N+2.
- Back-pressure: ioctl_wait=1 in the cycle after the FIFO occupancy becomes ≥1, and stays high until it returns to 0.
- Simultaneous push and pop on a full FIFO: the pop completes first and the push is accepted; no error is raised.
- cpu_hold rises in the cycle after the download is detected. It falls exactly HOLD_TAIL cycles after entry to TAIL.

## Structure
- A shared package aim65_pkg holds:
  - the state enum (IDLE/LOAD/DRAIN/TAIL);
  - ROM index constants (monitor, BASIC, assembler);
  - base-address constants.
- One sub-module, loader_fifo: a 2-entry synchronous FIFO with parameterised width and full/empty flags.

## Test plan
- 16-byte download, index 0, mem_ready=1, data 0x01..0x10 → 16 mem_we pulses at addresses 0..15; byte_count=16; checksum=0x88; load_done=1; load_err=0.
- Same stream with mem_ready low for 5 cycles mid-stream → ioctl_wait=1 throughout the stall; no bytes lost; final checksum=0x88.
- Byte at ioctl_addr=DEPTH → no write; load_err=1; load_done=0 after TAIL; byte_count excludes the dropped byte.
- Download with ioctl_index=1 → mem_we never asserted; cpu_hold stays 0; outputs unchanged.
- reset asserted after 4 of 16 bytes → all outputs 0 on the next edge; the remaining strobes of that download produce no writes.
- Download end → cpu_hold stays high exactly HOLD_TAIL=16 cycles after the FIFO drains, then 0; load_done rises in the same cycle.
